// File: rtl/pts_16_pkg.sv
// Shared types and constants for the 16-sample parallel-to-serial converter.
package pts_16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NSAMP = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic signed [WIDTH-1:0] sample_t;
    // Index 0 holds y_00, the first sample on the wire.
    typedef sample_t [NSAMP-1:0] frame_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMP - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(NSAMP - 2);

endpackage

// File: rtl/pts_16_if.sv
// Frame-load and serial-output handshake bundle for pts_16.
interface pts_16_if;
    import pts_16_pkg::*;

    logic    load_valid;
    logic    load_ready;
    sample_t y_00, y_01, y_02, y_03, y_04, y_05, y_06, y_07;
    sample_t y_08, y_09, y_10, y_11, y_12, y_13, y_14, y_15;
    logic    pts_ready;
    logic    pts_valid;
    sample_t pts_d;
    logic    pts_last;

    modport master (
        output load_valid, pts_ready,
        output y_00, y_01, y_02, y_03, y_04, y_05, y_06, y_07,
        output y_08, y_09, y_10, y_11, y_12, y_13, y_14, y_15,
        input  load_ready, pts_valid, pts_d, pts_last
    );

    modport slave (
        input  load_valid, pts_ready,
        input  y_00, y_01, y_02, y_03, y_04, y_05, y_06, y_07,
        input  y_08, y_09, y_10, y_11, y_12, y_13, y_14, y_15,
        output load_ready, pts_valid, pts_d, pts_last
    );

endinterface

// File: rtl/pts_shift16.sv
// 16x16 loadable shift register; shifts toward index 0 and exposes the head sample.
module pts_shift16
    import pts_16_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    shift,
    input  frame_t  din,
    output sample_t head
);

    frame_t sh;

    // Load wins over shift; zeros fill in behind the departing head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= {sample_t'(0), sh[NSAMP-1:1]};
        end
    end

    assign head = sh[0];

endmodule

// File: rtl/pts_16.sv
// Parallel-to-serial converter: one 16-sample frame in, y_00..y_15 out, with a one-frame holding buffer.
module pts_16
    import pts_16_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    pts_16_if.slave  bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_full;
    frame_t           pending;
    logic             pts_valid_q;
    logic             pts_last_q;
    logic             load_ready_q;

    frame_t  frame_in;
    frame_t  sh_din;
    logic    sh_load;
    logic    sh_shift;
    sample_t head;
    logic    xfer;
    logic    load_acc;
    logic    last_beat;

    assign frame_in = {bus.y_15, bus.y_14, bus.y_13, bus.y_12,
                       bus.y_11, bus.y_10, bus.y_09, bus.y_08,
                       bus.y_07, bus.y_06, bus.y_05, bus.y_04,
                       bus.y_03, bus.y_02, bus.y_01, bus.y_00};

    assign xfer      = pts_valid_q && bus.pts_ready;
    assign load_acc  = bus.load_valid && load_ready_q;
    assign last_beat = xfer && (cnt == CNT_LAST);

    // Shifter control: on the final beat reload from pending, then the port, else clear to zero.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = frame_in;
        if (state == IDLE) begin
            sh_load = load_acc;
        end else if (last_beat) begin
            sh_load = 1'b1;
            if (pend_full) begin
                sh_din = pending;
            end else if (!load_acc) begin
                sh_din = '0;
            end
        end else begin
            sh_shift = xfer;
        end
    end

    pts_shift16 u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pend_full    <= 1'b0;
            pending      <= '0;
            pts_valid_q  <= 1'b0;
            pts_last_q   <= 1'b0;
            load_ready_q <= 1'b1;
        end else if (state == IDLE) begin
            if (load_acc) begin
                state       <= SHIFT;
                cnt         <= '0;
                pts_valid_q <= 1'b1;
                pts_last_q  <= 1'b0;
            end
        end else if (last_beat) begin
            cnt        <= '0;
            pts_last_q <= 1'b0;
            if (pend_full) begin
                pend_full    <= 1'b0;
                load_ready_q <= 1'b1;
            end else if (!load_acc) begin
                state       <= IDLE;
                pts_valid_q <= 1'b0;
            end
        end else begin
            if (xfer) begin
                cnt        <= cnt + CNT_W'(1);
                pts_last_q <= (cnt == CNT_PRE);
            end
            // A load mid-frame parks in the holding buffer until the final beat.
            if (load_acc) begin
                pending      <= frame_in;
                pend_full    <= 1'b1;
                load_ready_q <= 1'b0;
            end
        end
    end

    assign bus.pts_valid  = pts_valid_q;
    assign bus.pts_d      = head;
    assign bus.pts_last   = pts_last_q;
    assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_pts_16.sv
// Self-checking bench for pts_16: every accepted frame queues its 16 samples; every transfer must pop them in order.
module tb_pts_16;
    import pts_16_pkg::*;

    typedef struct {
        sample_t d;
        logic    last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pts_16_if bus ();

    pts_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t   exp_q[$];
    frame_t cur;
    int     errors = 0;
    int     checks = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_frame(input frame_t f);
        cur      = f;
        bus.y_00 = f[0];  bus.y_01 = f[1];  bus.y_02 = f[2];  bus.y_03 = f[3];
        bus.y_04 = f[4];  bus.y_05 = f[5];  bus.y_06 = f[6];  bus.y_07 = f[7];
        bus.y_08 = f[8];  bus.y_09 = f[9];  bus.y_10 = f[10]; bus.y_11 = f[11];
        bus.y_12 = f[12]; bus.y_13 = f[13]; bus.y_14 = f[14]; bus.y_15 = f[15];
    endtask

    // Samples the handshakes seen by the coming edge, updates the model queue, advances one cycle.
    task automatic tick(output logic xf, output sample_t d, output logic last, output logic ld);
        exp_t e;
        xf   = bus.pts_valid && bus.pts_ready;
        d    = bus.pts_d;
        last = bus.pts_last;
        ld   = bus.load_valid && bus.load_ready;
        if (ld) begin
            for (int k = 0; k < int'(NSAMP); k++) begin
                e.d    = cur[k];
                e.last = (k == int'(NSAMP) - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.load_valid = 1'b0;
        bus.pts_ready  = 1'b0;
        set_frame('0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.pts_valid); end
        checks++; if (bus.pts_d !== 16'sd0) begin errors++; $display("FAIL reset_d: got %h want 0000", bus.pts_d); end
        checks++; if (bus.pts_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.pts_last); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Single frame with pts_ready held high: 1-cycle latency, 16 contiguous samples, then idle.
    task automatic test_frame(input string name, input frame_t f);
        logic xf, last, ld;
        sample_t d;
        exp_t e;
        bus.pts_ready = 1'b1;
        set_frame(f);
        bus.load_valid = 1'b1;
        tick(xf, d, last, ld);
        bus.load_valid = 1'b0;
        checks++; if (ld !== 1'b1) begin errors++; $display("FAIL %s_load: accepted=%b want 1", name, ld); end
        checks++;
        if (bus.pts_valid !== 1'b1 || bus.pts_d !== f[0]) begin
            errors++; $display("FAIL %s_latency: valid=%b d=%h want valid=1 d=%h", name, bus.pts_valid, bus.pts_d, f[0]);
        end
        for (int i = 0; i < int'(NSAMP); i++) begin
            tick(xf, d, last, ld);
            checks++;
            if (!xf || exp_q.size() == 0) begin
                errors++; $display("FAIL %s_beat%0d: xfer=%b queued=%0d want a transfer", name, i, xf, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (d !== e.d || last !== e.last) begin
                    errors++; $display("FAIL %s_beat%0d: d=%h last=%b want d=%h last=%b", name, i, d, last, e.d, e.last);
                end
            end
        end
        checks++;
        if (bus.pts_valid !== 1'b0 || bus.pts_d !== 16'sd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL %s_idle: valid=%b d=%h queued=%0d want 0 0000 0", name, bus.pts_valid, bus.pts_d, exp_q.size());
        end
    endtask

    // Frame B offered while A shifts: B parks, then 32 samples with no gap.
    task automatic test_back_to_back();
        logic xf, last, ld;
        sample_t d;
        exp_t e;
        frame_t a, b;
        for (int k = 0; k < int'(NSAMP); k++) begin
            a[k] = sample_t'(16'h0100 + k);
            b[k] = sample_t'(16'h0200 + k);
        end
        bus.pts_ready = 1'b1;
        set_frame(a);
        bus.load_valid = 1'b1;
        tick(xf, d, last, ld);
        bus.load_valid = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            if (t == 3) begin set_frame(b); bus.load_valid = 1'b1; end
            if (t == 4) begin
                checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", bus.load_ready); end
            end
            if (t == 17) begin
                checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_high: got %b want 1", bus.load_ready); end
            end
            tick(xf, d, last, ld);
            if (ld) bus.load_valid = 1'b0;
            checks++;
            if (!xf || exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_beat%0d: xfer=%b queued=%0d want a transfer", t, xf, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (d !== e.d || last !== e.last) begin
                    errors++; $display("FAIL b2b_beat%0d: d=%h last=%b want d=%h last=%b", t, d, last, e.d, e.last);
                end
            end
        end
        checks++;
        if (bus.pts_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_end: valid=%b queued=%0d want 0 0", bus.pts_valid, exp_q.size());
        end
    endtask

    // pts_ready cycles 1,0,0,1: output must hold through stalls, each sample exactly once.
    task automatic test_stall();
        logic xf, last, ld, prev_stall;
        sample_t d, prev_d;
        exp_t e;
        frame_t f;
        int got;
        for (int k = 0; k < int'(NSAMP); k++) f[k] = sample_t'($urandom);
        bus.pts_ready = 1'b1;
        set_frame(f);
        bus.load_valid = 1'b1;
        tick(xf, d, last, ld);
        bus.load_valid = 1'b0;
        got = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 80 && got < int'(NSAMP); i++) begin
            bus.pts_ready = (i % 4 == 0) || (i % 4 == 3);
            if (prev_stall) begin
                checks++;
                if (bus.pts_valid !== 1'b1 || bus.pts_d !== prev_d) begin
                    errors++; $display("FAIL stall_hold%0d: valid=%b d=%h want 1 %h", i, bus.pts_valid, bus.pts_d, prev_d);
                end
            end
            prev_stall = bus.pts_valid && !bus.pts_ready;
            prev_d     = bus.pts_d;
            tick(xf, d, last, ld);
            if (xf) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra: d=%h with empty queue", d);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e.d || last !== e.last) begin
                        errors++; $display("FAIL stall_beat%0d: d=%h last=%b want d=%h last=%b", got, d, last, e.d, e.last);
                    end
                end
            end
        end
        checks++;
        if (got != int'(NSAMP) || bus.pts_valid !== 1'b0) begin
            errors++; $display("FAIL stall_count: got %0d samples valid=%b want 16 0", got, bus.pts_valid);
        end
    endtask

    // New frame accepted on the final beat with pending empty: no idle gap.
    task automatic test_load_on_last();
        logic xf, last, ld;
        sample_t d;
        exp_t e;
        frame_t c, nf;
        for (int k = 0; k < int'(NSAMP); k++) begin
            c[k]  = sample_t'($urandom);
            nf[k] = sample_t'($urandom);
        end
        bus.pts_ready = 1'b1;
        set_frame(c);
        bus.load_valid = 1'b1;
        tick(xf, d, last, ld);
        bus.load_valid = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            if (t == 16) begin
                checks++;
                if (bus.pts_last !== 1'b1 || bus.load_ready !== 1'b1) begin
                    errors++; $display("FAIL lol_final: last=%b load_ready=%b want 1 1", bus.pts_last, bus.load_ready);
                end
                set_frame(nf);
                bus.load_valid = 1'b1;
            end
            tick(xf, d, last, ld);
            if (ld) bus.load_valid = 1'b0;
            checks++;
            if (!xf || exp_q.size() == 0) begin
                errors++; $display("FAIL lol_beat%0d: xfer=%b queued=%0d want a transfer", t, xf, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (d !== e.d || last !== e.last) begin
                    errors++; $display("FAIL lol_beat%0d: d=%h last=%b want d=%h last=%b", t, d, last, e.d, e.last);
                end
            end
        end
        checks++;
        if (bus.pts_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL lol_end: valid=%b queued=%0d want 0 0", bus.pts_valid, exp_q.size());
        end
    endtask

    // Async reset at sample 7 with a frame pending: outputs clear at once and nothing old reappears.
    task automatic test_reset_mid();
        logic xf, last, ld;
        sample_t d;
        frame_t f1, f2;
        int stray;
        for (int k = 0; k < int'(NSAMP); k++) begin
            f1[k] = sample_t'($urandom);
            f2[k] = sample_t'($urandom);
        end
        bus.pts_ready = 1'b1;
        set_frame(f1);
        bus.load_valid = 1'b1;
        tick(xf, d, last, ld);
        bus.load_valid = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            if (t == 3) begin set_frame(f2); bus.load_valid = 1'b1; end
            tick(xf, d, last, ld);
            if (ld) bus.load_valid = 1'b0;
        end
        checks++;
        if (bus.pts_d !== f1[7] || bus.load_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: d=%h load_ready=%b want %h 0", bus.pts_d, bus.load_ready, f1[7]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.pts_valid !== 1'b0 || bus.pts_d !== 16'sd0 || bus.pts_last !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_async: valid=%b d=%h last=%b load_ready=%b want 0 0000 0 1",
                               bus.pts_valid, bus.pts_d, bus.pts_last, bus.load_ready);
        end
        exp_q.delete();
        bus.load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 24; i++) begin
            tick(xf, d, last, ld);
            if (xf || bus.pts_valid) stray++;
        end
        checks++;
        if (stray != 0 || bus.load_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_after: stray=%0d load_ready=%b want 0 1", stray, bus.load_ready);
        end
    endtask

    // Random frames and random backpressure, then drain.
    task automatic test_random();
        logic xf, last, ld, prev_stall;
        sample_t d, prev_d;
        exp_t e;
        frame_t f;
        int n;
        prev_stall = 1'b0;
        prev_d = '0;
        bus.load_valid = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bus.pts_ready = ($urandom_range(0, 3) != 0);
            if (!bus.load_valid && $urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'(NSAMP); k++) f[k] = sample_t'($urandom);
                set_frame(f);
                bus.load_valid = 1'b1;
            end
            if (prev_stall) begin
                checks++;
                if (bus.pts_valid !== 1'b1 || bus.pts_d !== prev_d) begin
                    errors++; $display("FAIL rnd_hold%0d: valid=%b d=%h want 1 %h", i, bus.pts_valid, bus.pts_d, prev_d);
                end
            end
            prev_stall = bus.pts_valid && !bus.pts_ready;
            prev_d     = bus.pts_d;
            tick(xf, d, last, ld);
            if (ld) bus.load_valid = 1'b0;
            if (xf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra%0d: d=%h with empty queue", i, d);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e.d || last !== e.last) begin
                        errors++; $display("FAIL rnd_beat%0d: d=%h last=%b want d=%h last=%b", i, d, last, e.d, e.last);
                    end
                end
            end
        end
        bus.pts_ready = 1'b1;
        n = 0;
        while (n < 200 && (bus.load_valid || bus.pts_valid || exp_q.size() != 0)) begin
            tick(xf, d, last, ld);
            if (ld) bus.load_valid = 1'b0;
            if (xf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_drain_extra: d=%h with empty queue", d);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e.d || last !== e.last) begin
                        errors++; $display("FAIL rnd_drain: d=%h last=%b want d=%h last=%b", d, last, e.d, e.last);
                    end
                end
            end
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.pts_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_end: queued=%0d valid=%b want 0 0", exp_q.size(), bus.pts_valid);
        end
    endtask

    initial begin
        frame_t f;
        test_reset();
        for (int k = 0; k < int'(NSAMP); k++) f[k] = sample_t'(k + 1);
        test_frame("single", f);
        for (int k = 0; k < int'(NSAMP); k++) f[k] = sample_t'(-(k + 1));
        test_frame("negative", f);
        test_back_to_back();
        test_stall();
        test_load_on_last();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
